side_buff_ctrl: RTL
===================

# side_buff_ctrl

Controller for the router's side buffer: a small FIFO that absorbs one deflected flit per cycle from the buffer-eject stage and reinjects buffered flits into free input slots of the next router cycle. It sits between the buff_eject stage (source of the side-buffer flit) and the input-port mux of the deflection arbiter. It also schedules forced redirection when the buffer starves for free slots.

## Interface
Parameters:
- FLIT_W, 11, flit width in bits
- DEPTH, 4, side-buffer entries (power of two, ≥2)
- REDIR_THRESH, 8, starvation cycles before a forced redirect (1..255)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- buf_in_vld  input  1  deflected flit offered to the side buffer this cycle
- buf_in_flit  input  FLIT_W  offered flit
- slot_busy  input  4  per-input-slot occupancy of the next cycle (0 east, 1 west, 2 north, 3 south)
- buf_accept  output  1  combinational: !full || pop_now
- reinj_vld  output  1  registered; reinjected flit valid
- reinj_flit  output  FLIT_W  registered; head flit being reinjected
- reinj_port  output  2  registered; slot the flit occupies
- redirect_req  output  1  registered; forced-redirect strobe
- count  output  clog2(DEPTH)+1  registered occupancy
- full, empty  output  1 each  decoded from count

## Operation
- FIFO: wr_ptr, rd_ptr (clog2(DEPTH) bits, wrap modulo DEPTH), count.
- push = buf_in_vld && buf_accept. Offered flit while buf_accept=0 is not stored; upstream must deflect instead.
- pop_now = !empty && (slot_busy != 4'b1111 || redir_fire).
- Free-slot pick: lowest-index zero bit of slot_busy (east > west > north > south priority).
- On pop: reinj_flit <= mem[rd_ptr]; reinj_port <= picked slot (or redir_ptr on forced redirect); reinj_vld <= 1; rd_ptr++.
- No pop: reinj_vld <= 0; reinj_flit, reinj_port hold.
- Simultaneous push and pop: count unchanged; push allowed when full because buf_accept includes pop_now. Push and pop on same entry when count=1: pop reads old head, new flit written to wr_ptr; no bypass from buf_in to reinj.
- Starvation FSM (states IDLE, WAIT, FIRE):
  - IDLE: empty or a free slot exists; starve_cnt=0. -> WAIT when !empty && slot_busy==4'b1111.
  - WAIT: starve_cnt++ each cycle all slots busy and !empty. -> IDLE on free slot or empty (cnt cleared). -> FIRE when starve_cnt reaches REDIR_THRESH-1.
  - FIRE: redir_fire=1 for exactly one cycle; pop forced onto slot redir_ptr; redirect_req registered high next cycle; redir_ptr rotates 0->1->2->3->0; -> IDLE.
- Displaced flit from the redirected slot returns via buf_in_vld in a later cycle; buffer has room because of the forced pop.

## Timing
- Reset (rst_n=0 at an edge): count=0, pointers=0, reinj_vld=0, reinj_flit=0, reinj_port=0, redirect_req=0, redir_ptr=0, FSM=IDLE, starve_cnt=0; full=0, empty=1. Memory contents not reset.
- Reset mid-operation discards all buffered flits; reset wins over push/pop in the same cycle.
- Push latency: flit counted at edge N; poppable at edge N+1 at earliest.
- Reinject: decision on inputs before edge N; reinj_* valid during cycle N..N+1.
- redirect_req high for exactly one cycle, coincident with the forced reinj_vld.
- Minimum forced-redirect spacing: REDIR_THRESH+1 cycles.

## Configuration
- SIDE_BUFF_REDIRECT_EN defined: starvation FSM, starve_cnt, redir_ptr present as above.
- Not defined: FSM and counters removed; redirect_req tied 0; pops occur only on a free slot; buffer may starve indefinitely.

## Test plan
- Reset: hold rst_n=0 two cycles with buf_in_vld=1 -> count=0, empty=1, reinj_vld=0, redirect_req=0.
- Fill: push 11'h101,11'h102,11'h103,11'h104 with slot_busy=4'b1111 -> count=4, full=1, buf_accept=0; fifth flit 11'h105 not stored.
- Reinject priority: count=2, slot_busy=4'b1010 -> next cycle reinj_vld=1, reinj_flit=11'h101, reinj_port=0; then slot_busy=4'b0111 -> reinj_flit=11'h102, reinj_port=3.
- Full push+pop: full, slot_busy=4'b1101, push 11'h1AA -> buf_accept=1, count stays 4, reinj_port=1, 11'h1AA emerges fourth.
- Redirect (macro on, REDIR_THRESH=8): count=1, slot_busy=4'b1111 held -> redirect_req=1 and reinj_vld=1 with reinj_port=0 after cycle 8; repeat -> reinj_port=1; count=0 after each.
- Redirect (macro off): same stimulus for 40 cycles -> redirect_req=0, reinj_vld=0, count=1 throughout.

Source files
------------

// File: rtl/side_buff_ctrl.sv
// side_buff_ctrl: side-buffer FIFO controller for the deflection router.
// It takes in one deflected flit per cycle from buff_eject. It reinjects the
// head flit into the lowest-index free input slot of the next router cycle.
// Optional feature macro: SIDE_BUFF_REDIRECT_EN. When it is defined, a
// starvation FSM forces a pop onto a rotating slot after REDIR_THRESH cycles
// during which every slot is busy. When it is undefined, redirect_req is
// tied low and pops happen only when a slot is free.
module side_buff_ctrl #(
  parameter int FLIT_W       = 11,
  parameter int DEPTH        = 4,
  parameter int REDIR_THRESH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     buf_in_vld,
  input  logic [FLIT_W-1:0]        buf_in_flit,
  input  logic [3:0]               slot_busy,
  output logic                     buf_accept,
  output logic                     reinj_vld,
  output logic [FLIT_W-1:0]        reinj_flit,
  output logic [1:0]               reinj_port,
  output logic                     redirect_req,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Reject illegal configurations at elaboration time.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("side_buff_ctrl: DEPTH must be a power of two >= 2");
  end
  if (REDIR_THRESH < 1 || REDIR_THRESH > 255) begin : g_bad_thresh
    $error("side_buff_ctrl: REDIR_THRESH must be in 1..255");
  end

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              reinj_vld_reg;
  logic [FLIT_W-1:0] reinj_flit_reg;
  logic [1:0]        reinj_port_reg;

  logic              all_busy;
  logic              redir_fire;
  logic              forced_pop;
  logic [1:0]        redir_ptr;
  logic              pop_now;
  logic              push;
  logic [3:0]        first_free;
  logic [3:0]        lower_free;
  logic [1:0]        pick_port;
  logic [1:0]        pop_port;

  assign all_busy = &slot_busy;
  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);

  // Free-slot pick: one-hot of the lowest-index idle slot (east first).
  assign lower_free[0] = 1'b0;
  for (genvar gi = 0; gi < 3; gi++) begin : g_lower
    assign lower_free[gi+1] = lower_free[gi] | ~slot_busy[gi];
  end
  for (genvar gi = 0; gi < 4; gi++) begin : g_first
    assign first_free[gi] = ~slot_busy[gi] & ~lower_free[gi];
  end
  assign pick_port = {first_free[3] | first_free[2], first_free[3] | first_free[1]};

  assign pop_now    = !empty && (!all_busy || redir_fire);
  assign buf_accept = !full || pop_now;
  assign push       = buf_in_vld && buf_accept;
  // A forced pop happens only when the FIRE cycle still sees all slots busy.
  // If a slot has just freed up, the normal pick is used.
  assign forced_pop = redir_fire && all_busy;
  assign pop_port   = forced_pop ? redir_ptr : pick_port;

`ifdef SIDE_BUFF_REDIRECT_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;

  logic [1:0] state_reg, state_next;
  logic [7:0] starve_cnt_reg, starve_cnt_next;
  logic [1:0] redir_ptr_reg;
  logic       redirect_req_reg;
  logic       starving;
  logic [7:0] starve_cnt_inc;

  assign starving       = !empty && all_busy;
  assign starve_cnt_inc = starve_cnt_reg + 8'd1;
  assign redir_fire     = (state_reg == ST_FIRE);
  assign redir_ptr      = redir_ptr_reg;
  assign redirect_req   = redirect_req_reg;

  // Starvation FSM next-state: count all-busy cycles, fire once at threshold.
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        starve_cnt_next = 8'd0;
        if (starving) begin
          state_next = (REDIR_THRESH == 1) ? ST_FIRE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!starving) begin
          state_next      = ST_IDLE;
          starve_cnt_next = 8'd0;
        end else begin
          starve_cnt_next = starve_cnt_inc;
          if (starve_cnt_inc >= 8'(REDIR_THRESH - 1)) begin
            state_next = ST_FIRE;
          end
        end
      end
      ST_FIRE: begin
        state_next      = ST_IDLE;
        starve_cnt_next = 8'd0;
      end
      default: begin
        state_next      = ST_IDLE;
        starve_cnt_next = 8'd0;
      end
    endcase
  end

  // Starvation state, redirect pointer rotation and redirect strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      starve_cnt_reg   <= 8'd0;
      redir_ptr_reg    <= 2'd0;
      redirect_req_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      starve_cnt_reg   <= starve_cnt_next;
      redirect_req_reg <= forced_pop && !empty;
      if (forced_pop && !empty) begin
        redir_ptr_reg <= redir_ptr_reg + 2'd1;
      end
    end
  end
`else
  assign redir_fire   = 1'b0;
  assign redir_ptr    = 2'd0;
  assign redirect_req = 1'b0;
`endif

  // Storage write port; contents are never reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr_reg] <= buf_in_flit;
    end
  end

  // Pointers, occupancy and the registered reinjection outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      reinj_vld_reg  <= 1'b0;
      reinj_flit_reg <= '0;
      reinj_port_reg <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_now) begin
        rd_ptr_reg     <= rd_ptr_reg + AW'(1);
        reinj_flit_reg <= mem[rd_ptr_reg];
        reinj_port_reg <= pop_port;
        reinj_vld_reg  <= 1'b1;
      end else begin
        reinj_vld_reg <= 1'b0;
      end
      count_reg <= count_reg + CW'(push) - CW'(pop_now);
    end
  end

  assign count      = count_reg;
  assign reinj_vld  = reinj_vld_reg;
  assign reinj_flit = reinj_flit_reg;
  assign reinj_port = reinj_port_reg;

endmodule
